// File: rtl/arcade_pause_ctrl.sv
// -----------------------------------------------------------------------------
// arcade_pause_ctrl
//   Pause and screen-dim controller placed between a game core's RGB outputs
//   and the video output stage.
//   - The raw pause button is synchronised, debounced, and each accepted press
//     toggles the user-pause state.
//   - The user pause is ORed with NUM_REQ external level requests to form the
//     core pause line.
//   - After the user has been paused for DIM_TIMEOUT cycles, the picture fades
//     one right-shift step every FADE_FRAMES vblank rising edges until DIM_MAX,
//     then holds there. Unpausing (or clearing dim_en) restores full brightness
//     on the very next clock.
//
// Ports
//   clk          in   core clock, rising edge
//   RESET_L      in   asynchronous active-low reset
//   pause_btn    in   raw pause button level (asynchronous), 1 = pressed
//   pause_req    in   [NUM_REQ] external pause requests, level, clk-synchronous
//   dim_en       in   1 = dimming allowed
//   vblank       in   core vertical blank, clk-synchronous
//   rgb_in       in   [3*RGB_W] {R,G,B} from the core
//   rgb_out      out  [3*RGB_W] {R,G,B} after dimming (1-cycle latency)
//   pause_out    out  user pause OR any pause_req (registered)
//   user_paused  out  current user-toggle state
//   dim_level    out  shift applied to every colour channel
// -----------------------------------------------------------------------------
module arcade_pause_ctrl #(
    parameter int          RGB_W       = 4,
    parameter int          NUM_REQ     = 2,
    parameter logic [15:0] DEBOUNCE    = 16'd1000,
    parameter logic [31:0] DIM_TIMEOUT = 32'd500000000,
    parameter int          DIM_MAX     = 2,
    parameter int          FADE_FRAMES = 8,
    localparam int         DIM_W       = $clog2(DIM_MAX + 1),
    localparam int         FC_W        = $clog2(FADE_FRAMES + 1)
) (
    input  logic                 clk,
    input  logic                 RESET_L,
    input  logic                 pause_btn,
    input  logic [NUM_REQ-1:0]   pause_req,
    input  logic                 dim_en,
    input  logic                 vblank,
    input  logic [3*RGB_W-1:0]   rgb_in,
    output logic [3*RGB_W-1:0]   rgb_out,
    output logic                 pause_out,
    output logic                 user_paused,
    output logic [DIM_W-1:0]     dim_level
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FADE = 2'd2,
        ST_HOLD = 2'd3
    } dim_state_t;

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic        btn_meta_reg;
    logic        btn_sync_reg;
    logic        deb_level_reg;
    logic        deb_prev_reg;
    logic [15:0] deb_cnt_reg;
    logic        user_paused_reg;

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            btn_meta_reg    <= 1'b0;
            btn_sync_reg    <= 1'b0;
            deb_level_reg   <= 1'b0;
            deb_prev_reg    <= 1'b0;
            deb_cnt_reg     <= '0;
            user_paused_reg <= 1'b0;
        end else begin
            btn_meta_reg <= pause_btn;
            btn_sync_reg <= btn_meta_reg;
            deb_prev_reg <= deb_level_reg;
            // The counter only runs while the synchronised level disagrees
            // with the accepted level; any agreement (a bounce) restarts it.
            if (btn_sync_reg != deb_level_reg) begin
                if (deb_cnt_reg == DEBOUNCE - 16'd1) begin
                    deb_level_reg <= btn_sync_reg;
                    deb_cnt_reg   <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 16'd1;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
            // Only a press (rising edge of the debounced level) toggles.
            if (deb_level_reg && !deb_prev_reg) begin
                user_paused_reg <= !user_paused_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Core pause line
    // ------------------------------------------------------------------
    logic pause_out_reg;

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            pause_out_reg <= 1'b0;
        end else begin
            pause_out_reg <= user_paused_reg | (|pause_req);
        end
    end

    // ------------------------------------------------------------------
    // Dim FSM
    // ------------------------------------------------------------------
    logic             vblank_prev_reg;
    logic             vblank_rise;
    dim_state_t       state_reg;
    logic [31:0]      timer_reg;
    logic [FC_W-1:0]  frame_cnt_reg;
    logic [DIM_W-1:0] dim_level_reg;

    assign vblank_rise = vblank & ~vblank_prev_reg;

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            vblank_prev_reg <= 1'b0;
            state_reg       <= ST_RUN;
            timer_reg       <= '0;
            frame_cnt_reg   <= '0;
            dim_level_reg   <= '0;
        end else begin
            vblank_prev_reg <= vblank;
            if (!user_paused_reg || !dim_en) begin
                // Undim immediately; this also wins over a fade step due in
                // the same cycle.
                state_reg     <= ST_RUN;
                timer_reg     <= '0;
                frame_cnt_reg <= '0;
                dim_level_reg <= '0;
            end else begin
                case (state_reg)
                    ST_RUN: begin
                        timer_reg     <= '0;
                        dim_level_reg <= '0;
                        state_reg     <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (timer_reg != 32'hFFFF_FFFF) begin
                            timer_reg <= timer_reg + 32'd1;
                        end
                        if (timer_reg == DIM_TIMEOUT - 32'd1) begin
                            state_reg     <= ST_FADE;
                            frame_cnt_reg <= '0;
                        end
                    end
                    ST_FADE: begin
                        if (vblank_rise) begin
                            if (frame_cnt_reg == FC_W'(FADE_FRAMES - 1)) begin
                                frame_cnt_reg <= '0;
                                dim_level_reg <= dim_level_reg + DIM_W'(1);
                                if (dim_level_reg == DIM_W'(DIM_MAX - 1)) begin
                                    state_reg <= ST_HOLD;
                                end
                            end else begin
                                frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        dim_level_reg <= DIM_W'(DIM_MAX);
                    end
                    default: begin
                        state_reg <= ST_RUN;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Video path: per-channel logical right shift, registered
    // ------------------------------------------------------------------
    logic [3*RGB_W-1:0] rgb_next;
    logic [3*RGB_W-1:0] rgb_out_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign rgb_next[gi*RGB_W +: RGB_W] = rgb_in[gi*RGB_W +: RGB_W] >> dim_level_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            rgb_out_reg <= '0;
        end else begin
            rgb_out_reg <= rgb_next;
        end
    end

    assign rgb_out     = rgb_out_reg;
    assign pause_out   = pause_out_reg;
    assign user_paused = user_paused_reg;
    assign dim_level   = dim_level_reg;

endmodule

// File: tb/tb_arcade_pause_ctrl.sv
`timescale 1ns/1ps
module tb_arcade_pause_ctrl;

    localparam int DB   = 4;
    localparam int TO   = 100;
    localparam int DMAX = 2;
    localparam int FF   = 2;

    logic        clk       = 1'b0;
    logic        RESET_L   = 1'b0;
    logic        pause_btn = 1'b0;
    logic [1:0]  pause_req = 2'b00;
    logic        dim_en    = 1'b0;
    logic        vblank    = 1'b0;
    logic [11:0] rgb_in    = 12'h000;
    logic [11:0] rgb_out;
    logic        pause_out;
    logic        user_paused;
    logic [1:0]  dim_level;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit vb_run   = 1'b0;
    bit rgb_rand = 1'b0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    arcade_pause_ctrl #(
        .RGB_W(4), .NUM_REQ(2), .DEBOUNCE(16'd4), .DIM_TIMEOUT(32'd100),
        .DIM_MAX(2), .FADE_FRAMES(2)
    ) dut (
        .clk(clk), .RESET_L(RESET_L), .pause_btn(pause_btn), .pause_req(pause_req),
        .dim_en(dim_en), .vblank(vblank), .rgb_in(rgb_in), .rgb_out(rgb_out),
        .pause_out(pause_out), .user_paused(user_paused), .dim_level(dim_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: button history window, pause-duration counter and
    // count of vblank rises seen after the timeout.
    // ------------------------------------------------------------------
    logic [7:0]  m_hist    = '0;
    logic        m_deb     = 1'b0;
    logic        m_pend    = 1'b0;
    logic        m_up      = 1'b0;
    logic        m_pause   = 1'b0;
    logic        m_vb_prev = 1'b0;
    int          m_len     = 0;
    int          m_rises   = 0;
    int          m_dim     = 0;
    logic [11:0] m_rgb     = '0;

    always @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            m_hist <= '0; m_deb <= 1'b0; m_pend <= 1'b0; m_up <= 1'b0;
            m_pause <= 1'b0; m_vb_prev <= 1'b0; m_len <= 0; m_rises <= 0;
            m_dim <= 0; m_rgb <= '0;
        end else begin
            automatic logic [7:0] h = {m_hist[6:0], pause_btn};
            automatic bit accept = 1'b1;
            automatic int len = 0;
            automatic int rises = 0;
            // Accepted once the synchronised button (2 samples old) has
            // disagreed with the debounced level for DB consecutive cycles.
            for (int j = 2; j < 2 + DB; j++) begin
                if (h[j] == m_deb) accept = 1'b0;
            end
            m_hist <= h;
            if (accept) m_deb <= ~m_deb;
            m_pend    <= accept && !m_deb;
            m_up      <= m_up ^ m_pend;
            m_pause   <= m_up | (|pause_req);
            m_vb_prev <= vblank;
            m_rgb     <= {rgb_in[11:8] >> m_dim, rgb_in[7:4] >> m_dim, rgb_in[3:0] >> m_dim};
            if (m_up && dim_en) begin
                len   = m_len + 1;
                rises = m_rises + ((len >= TO + 2 && vblank && !m_vb_prev) ? 1 : 0);
                m_len   <= len;
                m_rises <= rises;
                m_dim   <= (rises / FF > DMAX) ? DMAX : rises / FF;
            end else begin
                m_len <= 0; m_rises <= 0; m_dim <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && RESET_L) begin
            check("mdl_rgb_out", rgb_out, m_rgb);
            check("mdl_pause_out", pause_out, m_pause);
            check("mdl_user_paused", user_paused, m_up);
            check("mdl_dim_level", dim_level, m_dim);
        end
    end

    // One clock: inputs change 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (vb_run) vblank = ((cyc % 20) < 3);
        if (rgb_rand) rgb_in = 12'($urandom);
    endtask

    task automatic wait_dim(input int lvl, input int budget, input string tag);
        int n = 0;
        while (dim_level != 2'(lvl) && n < budget) begin
            step();
            n++;
        end
        check(tag, dim_level, lvl);
    endtask

    task automatic press();
        pause_btn = 1'b1;
        repeat (10) step();
        pause_btn = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        logic [11:0] v;
        // Reset state
        #3;
        check("rst_rgb_out", rgb_out, 0);
        check("rst_pause_out", pause_out, 0);
        check("rst_user_paused", user_paused, 0);
        check("rst_dim_level", dim_level, 0);
        step(); step();
        RESET_L = 1'b1;
        mon_en  = 1'b1;
        step();

        // External requests only: pause_out follows one cycle late, no dim
        dim_en = 1'b1;
        vb_run = 1'b1;
        check("t2_pre", pause_out, 0);
        pause_req = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_pause_on", pause_out, 1);
            check("t2_dim", dim_level, 0);
        end
        pause_req = 2'b00;
        step();
        check("t2_pause_off", pause_out, 0);
        repeat (5) step();

        // Bouncing button, then settle high
        rgb_in = 12'hFFF;
        for (int i = 0; i < 20; i++) begin
            pause_btn = ((i / 2) % 2 == 0);
            step();
            check("t1_bounce", user_paused, 0);
        end
        pause_btn = 1'b1;
        repeat (6) step();
        check("t1_not_yet", user_paused, 0);
        step();
        check("t1_toggled", user_paused, 1);

        // Full fade
        for (int i = 0; i < 100; i++) begin
            step();
            check("t3_rgb_full", rgb_out, 12'hFFF);
        end
        wait_dim(1, 200, "t3_dim1");
        step();
        check("t3_rgb777", rgb_out, 12'h777);
        wait_dim(2, 200, "t3_dim2");
        step();
        check("t3_rgb333", rgb_out, 12'h333);
        repeat (60) step();
        check("t3_hold", dim_level, 2);

        // Release has no effect; then unpause from HOLD
        pause_btn = 1'b0;
        repeat (10) step();
        check("t4_fall_noop", user_paused, 1);
        press();
        check("t4_unpause_hold", dim_level, 0);
        // Re-pause, unpause at dim_level 1
        press();
        check("t4_repaused", user_paused, 1);
        wait_dim(1, 400, "t4_dim1");
        pause_btn = 1'b1;
        repeat (7) step();
        check("t4_unpaused", user_paused, 0);
        step();
        check("t4_dim0", dim_level, 0);
        v = 12'($urandom);
        rgb_in = v;
        step();
        check("t4_passthru", rgb_out, v);
        pause_btn = 1'b0;
        repeat (10) step();

        // dim_en low: long pause, never dims
        dim_en   = 1'b0;
        rgb_rand = 1'b1;
        press();
        for (int i = 0; i < 1000; i++) begin
            step();
            check("t5_dim0", dim_level, 0);
            check("t5_pause", pause_out, 1);
        end

        // Asynchronous reset during HOLD
        dim_en = 1'b1;
        wait_dim(2, 400, "t6_hold");
        @(posedge clk);
        #2;
        RESET_L = 1'b0;
        #1;
        check("t6_rgb_out", rgb_out, 0);
        check("t6_pause_out", pause_out, 0);
        check("t6_user_paused", user_paused, 0);
        check("t6_dim_level", dim_level, 0);
        step(); step();
        RESET_L = 1'b1;

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(7) == 0) pause_req = 2'($urandom);
            if ($urandom_range(399) == 0) dim_en = ~dim_en;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
